serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor. Computes D = A - B LSB-first, one bit per clock, with a start/busy/done handshake.
- Uses a half-subtractor pair per bit-slice; it is the inverse-operation companion to the team's adder blocks.
- Sits in the arithmetic examples library as the first sequential datapath block. It feeds a self-checking bench.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when the block is not busy.
- A  input  WIDTH  minuend; captured on an accepted start.
- B  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when D/BOUT become valid.
- D  output  WIDTH  difference, A - B mod 2^WIDTH.
- BOUT  output  1  final borrow; 1 when A < B (unsigned).
- OVF  output  1  signed overflow; present only with the optional feature.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low.
- Reset (rst_n=0): state=IDLE, busy=0, done=0, D=0, BOUT=0, OVF=0. Internal shift registers, bit counter and borrow are cleared.
- State IDLE:
  - start=1 at a rising edge: latch A and B into shift regs, counter=0, borrow=0, D cleared, go to RUN.
- State RUN (busy=1), each edge:
  - a = areg[0], b = breg[0].
  - d = a ^ b ^ borrow.
  - borrow_next = (~a & b) | (~(a ^ b) & borrow).
  - areg and breg shift right by 1; d shifts into D at the MSB, so the result is fully aligned after WIDTH shifts.
  - counter increments.
  - On the edge where counter reaches WIDTH-1: load BOUT = borrow_next, go to DONE.
- State DONE (busy=0, done=1 for exactly one cycle):
  - start=1 in this cycle: accepted as a new operation (back-to-back), go to RUN.
  - Otherwise: go to IDLE.
- Latency: start sampled at edge k -> done high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- D, BOUT and OVF hold their values after done until the next accepted start clears D.
- start is ignored while busy=1. A and B may change freely after acceptance.
- Width rules:
  - counter width is $clog2(WIDTH).
  - All arithmetic is modulo 2^WIDTH.
  - D is never sign-extended.
- Reset mid-operation returns immediately to the reset values; no done pulse is produced.
- Boundary cases:
  - A == B -> D=0, BOUT=0.
  - A=0, B=2^WIDTH-1 -> D=1, BOUT=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Port OVF exists.
  - At the last bit, OVF = (a ^ b) & (a ^ d), computed on the sign bits of the operands and result.
  - OVF is registered together with BOUT, and is valid when done is high.
- Undefined:
  - Port OVF and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package arith_pkg:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Localparam helper for the counter width.
- Sub-module half_subtractor (inputs X, Y; outputs Dif = X^Y, Bor = ~X&Y).
  - The top instantiates two half_subtractor cells plus an OR gate to form the full-subtract bit-slice.
  - The bench also exercises half_subtractor standalone over all four input combinations.

Test Plan:
- WIDTH=4, A=5, B=3, start pulse -> busy for 4 cycles, then done pulse with D=2, BOUT=0.
- WIDTH=4, A=3, B=5 -> D=4'hE, BOUT=1. Then A=B=4'hF -> D=0, BOUT=0.
- start held high during RUN with new A=9, B=1 -> ignored; the first result is unchanged. Done must appear exactly WIDTH+1 cycles after the first accepted start.
- Back-to-back: start asserted in the DONE cycle with A=8, B=1 -> no IDLE cycle, next done gives D=7, BOUT=0.
- rst_n driven low at bit 2 of a run -> busy=0, done=0, D=0 asynchronously. A following run with A=6, B=6 gives D=0.
- With SERIAL_SUBTRACTOR_OVF_EN, WIDTH=4:
  - A=4'b0111, B=4'b1000 -> D=4'hF, OVF=1.
  - A=2, B=1 -> OVF=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic examples library:
// FSM state encoding of the sequential datapath blocks and a counter-width helper.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to count 0..w-1; never less than one so the counter always exists.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor cell: Dif = X - Y (one bit), Bor = borrow out.
// Two of these plus an OR gate form one full-subtract bit-slice.
module half_subtractor (
    input  logic X,
    input  logic Y,
    output logic Dif,
    output logic Bor
);

    assign Dif = X ^ Y;
    assign Bor = ~X & Y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B mod 2^WIDTH, LSB first, one bit per clock.
// start is accepted in IDLE or in the DONE cycle (back-to-back); done pulses one cycle
// after the last bit. Optional signed-overflow output enabled by the macro
// SERIAL_SUBTRACTOR_OVF_EN (port OVF exists only when it is defined).
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             OVF,
`endif
    output logic             BOUT
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] areg_q,   areg_d;
    logic [WIDTH-1:0] breg_q,   breg_d;
    logic [WIDTH-1:0] dreg_q,   dreg_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q,   bout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    // Full-subtract bit-slice built from two half subtractors.
    logic bit_a_s, bit_b_s;
    logic hs0_dif_s, hs0_bor_s;
    logic bit_d_s, hs1_bor_s;
    logic borrow_next_s;

    assign bit_a_s = areg_q[0];
    assign bit_b_s = breg_q[0];

    half_subtractor u_hs0 (
        .X   (bit_a_s),
        .Y   (bit_b_s),
        .Dif (hs0_dif_s),
        .Bor (hs0_bor_s)
    );

    half_subtractor u_hs1 (
        .X   (hs0_dif_s),
        .Y   (borrow_q),
        .Dif (bit_d_s),
        .Bor (hs1_bor_s)
    );

    assign borrow_next_s = hs0_bor_s | hs1_bor_s;

    // Next-state logic: operand capture, per-bit shift/accumulate, and final flag load.
    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        dreg_d   = dreg_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    areg_d   = A;
                    breg_d   = B;
                    dreg_d   = {WIDTH{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                areg_d   = {1'b0, areg_q[WIDTH-1:1]};
                breg_d   = {1'b0, breg_q[WIDTH-1:1]};
                // New bit enters at the MSB so the word is aligned after WIDTH shifts.
                dreg_d   = {bit_d_s, dreg_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                borrow_d = borrow_next_s;
                if (cnt_q == LAST_CNT) begin
                    bout_d  = borrow_next_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // Sign bits of A, B and D are the operands of this last slice.
                    ovf_d   = (bit_a_s ^ bit_b_s) & (bit_a_s ^ bit_d_s);
`endif
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            areg_q   <= {WIDTH{1'b0}};
            breg_q   <= {WIDTH{1'b0}};
            dreg_q   <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            dreg_q   <= dreg_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = dreg_q;
    assign BOUT = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) and the half_subtractor cell.
// A cycle-level behavioural model (plain arithmetic on whole words) predicts
// busy/done/D/BOUT; a negedge process compares every cycle. Directed cases pin the
// model with literal values, then randomized operations run against it.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy, done, BOUT;
    logic [W-1:0] D;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         OVF;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .OVF   (OVF),
`endif
        .BOUT  (BOUT)
    );

    logic hx = 1'b0, hy = 1'b0, hd, hb;
    half_subtractor u_hs (.X(hx), .Y(hy), .Dif(hd), .Bor(hb));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed overflow: true result of the signed subtraction falls outside W-bit range.
    function automatic bit ovf_of(input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        r = int'($signed(a)) - int'($signed(b));
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    // Behavioural model: an accepted start makes the block busy for W cycles, then
    // done for one cycle with the whole-word result.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_d = '0, p_d = '0;
    bit           m_bout = 1'b0, p_bout = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_d    <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (start && m_left == 0) begin
            m_left <= W;
            m_done <= 1'b0;
            m_d    <= '0;
            p_d    <= A - B;
            p_bout <= (A < B);
            p_ovf  <= ovf_of(A, B);
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_d    <= p_d;
                m_bout <= p_bout;
                m_ovf  <= p_ovf;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, (m_left > 0));
            check("done", done, m_done);
            if (m_left == 0) begin
                check("D", D, m_d);
                check("BOUT", BOUT, m_bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("OVF", OVF, m_ovf);
`endif
            end
        end
    end

    // Issue an operation at a negedge, keep start high for 'hold' cycles (scrambling
    // A/B meanwhile), and return the number of negedges until done is seen.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output int lat);
        A = a;
        B = b;
        start = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat >= hold) begin
                start = 1'b0;
            end else begin
                A = W'($urandom);
                B = W'($urandom);
            end
            if (done || lat >= 40) break;
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
    endtask

    initial begin
        int lat;
        logic [3:0] dif_tab;
        logic [3:0] bor_tab;
        logic [1:0] idx;

        // Half subtractor exhaustive: index = {X,Y}.
        dif_tab = 4'b0110;
        bor_tab = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            hx = idx[1];
            hy = idx[0];
            #1;
            check("hs_dif", hd, dif_tab[idx]);
            check("hs_bor", hb, bor_tab[idx]);
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_d", D, 4'h0);
        check("rst_bout", BOUT, 1'b0);

        issue(4'd5, 4'd3, 1, lat);
        check("lat_5_3", lat, W + 1);
        check("d_5_3", D, 4'h2);
        check("bout_5_3", BOUT, 1'b0);

        @(negedge clk);
        issue(4'd3, 4'd5, 1, lat);
        check("d_3_5", D, 4'hE);
        check("bout_3_5", BOUT, 1'b1);

        @(negedge clk);
        issue(4'hF, 4'hF, 1, lat);
        check("d_f_f", D, 4'h0);
        check("bout_f_f", BOUT, 1'b0);

        @(negedge clk);
        issue(4'h0, 4'hF, 1, lat);
        check("d_0_f", D, 4'h1);
        check("bout_0_f", BOUT, 1'b1);

        // start held during RUN with other operands: ignored.
        @(negedge clk);
        issue(4'd5, 4'd3, 3, lat);
        check("lat_held", lat, W + 1);
        check("d_held", D, 4'h2);

        // Back-to-back from the DONE cycle.
        issue(4'd8, 4'd1, 1, lat);
        check("lat_b2b", lat, W + 1);
        check("d_b2b", D, 4'h7);
        check("bout_b2b", BOUT, 1'b0);

        // Reset during bit 2 of a run.
        @(negedge clk);
        A = 4'd4;
        B = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_d", D, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd6, 4'd6, 1, lat);
        check("d_6_6", D, 4'h0);
        check("bout_6_6", BOUT, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        @(negedge clk);
        issue(4'b0111, 4'b1000, 1, lat);
        check("d_7_8", D, 4'hF);
        check("ovf_7_8", OVF, 1'b1);
        @(negedge clk);
        issue(4'd2, 4'd1, 1, lat);
        check("ovf_2_1", OVF, 1'b0);
`endif

        // Randomized operations: random gaps, holds and back-to-back starts.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            issue(W'($urandom), W'($urandom), $urandom_range(1, 3), lat);
            check("lat_rand", lat, W + 1);
        end

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
